// File: rtl/multicycle_control.sv
// Multicycle processor control FSM: sequences IF/ID/EX/MEM/WB per opcode,
// decodes datapath enables and counts retired instructions.
module multicycle_control (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [6:0]  OPCODE,
    input  logic        BR_TAKEN,
    input  logic        HALT_IN,
    output logic        IR_WREN,
    output logic        PC_WREN,
    output logic        ALUOUT_WREN,
    output logic [1:0]  PC_SRC,
    output logic        RF_WE,
    output logic        D_MEM_REQ,
    output logic        D_MEM_WEN,
    output logic [2:0]  STATE,
    output logic [31:0] NUM_INST,
    output logic        HALT
);

    localparam int unsigned OPC_W = 7;
    localparam int unsigned CNT_W = 32;

    localparam logic [OPC_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRC_PC4    = 2'b00;
    localparam logic [1:0] SRC_ALUOUT = 2'b01;
    localparam logic [1:0] SRC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        S_IF     = 3'd0,
        S_ID     = 3'd1,
        S_EX     = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    state_t state;
    state_t state_next;
    logic   op_known;
    logic   op_load;
    logic   op_store;
    logic   op_branch;
    logic   op_jump;

    // Opcode class decode of the instruction register
    always_comb begin
        op_load   = (OPCODE == OP_LOAD);
        op_store  = (OPCODE == OP_STORE);
        op_branch = (OPCODE == OP_BRANCH);
        op_jump   = (OPCODE == OP_JAL) || (OPCODE == OP_JALR);
        op_known  = op_load || op_store || op_branch || op_jump
                 || (OPCODE == OP_RTYPE) || (OPCODE == OP_ITYPE)
                 || (OPCODE == OP_LUI)   || (OPCODE == OP_AUIPC);
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!RSTn) state <= S_IF;
        else       state <= state_next;
    end

    // Next-state and datapath enable decode; reset masks every side effect
    always_comb begin
        state_next  = state;
        IR_WREN     = 1'b0;
        PC_WREN     = 1'b0;
        ALUOUT_WREN = 1'b0;
        PC_SRC      = SRC_PC4;
        RF_WE       = 1'b0;
        D_MEM_REQ   = 1'b0;
        D_MEM_WEN   = 1'b1;
        HALT        = 1'b0;
        case (state)
            S_IF: begin
                IR_WREN    = 1'b1;
                state_next = S_ID;
            end
            S_ID: begin
                if (HALT_IN) begin
                    state_next = S_HALTED;
                end else if (!op_known) begin
                    PC_WREN    = 1'b1;
                    state_next = S_IF;
                end else begin
                    state_next = S_EX;
                end
            end
            S_EX: begin
                ALUOUT_WREN = 1'b1;
                if (op_branch) begin
                    PC_WREN    = 1'b1;
                    PC_SRC     = BR_TAKEN ? SRC_ALUOUT : SRC_PC4;
                    state_next = S_IF;
                end else if (op_load || op_store) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                D_MEM_REQ = 1'b1;
                if (op_store) begin
                    D_MEM_WEN  = 1'b0;
                    PC_WREN    = 1'b1;
                    state_next = S_IF;
                end else if (op_load) begin
                    state_next = S_WB;
                end else begin
                    state_next = S_IF;
                end
            end
            S_WB: begin
                RF_WE      = 1'b1;
                PC_WREN    = 1'b1;
                PC_SRC     = op_jump ? SRC_JUMP : SRC_PC4;
                state_next = S_IF;
            end
            S_HALTED: begin
                HALT       = 1'b1;
                state_next = S_HALTED;
            end
            default: state_next = S_IF;
        endcase
        if (!RSTn) begin
            IR_WREN     = 1'b0;
            PC_WREN     = 1'b0;
            ALUOUT_WREN = 1'b0;
            PC_SRC      = SRC_PC4;
            RF_WE       = 1'b0;
            D_MEM_REQ   = 1'b0;
            D_MEM_WEN   = 1'b1;
            HALT        = 1'b0;
        end
    end

    // Retired-instruction counter: one per PC update, wraps naturally
    always_ff @(posedge CLK) begin
        if (!RSTn)        NUM_INST <= '0;
        else if (PC_WREN) NUM_INST <= NUM_INST + CNT_W'(1);
    end

    // Debug view of the current state
    always_comb begin
        STATE = 3'(state);
    end

endmodule
